cmp_zelg_sar: RTL
=================

// Module: cmp_zelg_sar
// PURPOSE
//  Successive-approximation (binary-search) driver for a CmpZelg-style magnitude comparator.
//  It drives the comparator's A operand (PROBE) and reads its E/L/G flags, where B is an unknown target
//  (e.g. SW[4:0]). It converges on the target value and reports the result.
//  It is the initiating side of the comparator interface: the comparator answers, this block asks.
//  It sits between a start request (debounced button) and LED/HEX result display.
// PARAMETERS
//  p_WIDTH   5  operand width in bits; search space 0 .. 2^p_WIDTH-1
//  p_SETTLE  1  cycles PROBE is held stable before flags are sampled (>=1; covers comparator/IO delay)
// PORTS
//  CLOCK_50  in   1             single clock, all logic on rising edge
//  RESET_N   in   1             synchronous reset, active-low
//  START     in   1             request a search; sampled only in IDLE
//  PROBE     out  p_WIDTH       comparator operand A
//  CMP_E     in   1             PROBE == target
//  CMP_L     in   1             PROBE <  target
//  CMP_G     in   1             PROBE >  target
//  BUSY      out  1             high from the cycle after START is accepted until DONE
//  DONE      out  1             one-cycle pulse: search finished, results valid
//  FOUND     out  1             result is valid (target located)
//  ERR       out  1             flags were inconsistent or the search bounds crossed
//  RESULT    out  p_WIDTH       located target value (held until next START)
//  ITER      out  $clog2(p_WIDTH+2)  number of probes used (held until next START)
// BEHAVIOUR
//  Reset (RESET_N=0 at an edge): state=IDLE; PROBE=0, BUSY=0, DONE=0, FOUND=0, ERR=0, RESULT=0, ITER=0.
//   Reset applies mid-search too: the search is abandoned and no DONE is produced.
//  lo, hi internal, p_WIDTH+1 bits. mid = lo + ((hi-lo)>>1). No wrap: bounds never go negative or past max.
//  FSM states: IDLE, DRIVE, WAIT, FIN.
//  IDLE:
//   - START=1 at an edge: lo=0, hi=2^p_WIDTH-1, ITER=0, FOUND=0, ERR=0, BUSY=1; go to DRIVE.
//   - START=0: remain in IDLE.
//  DRIVE: PROBE<=mid, ITER<=ITER+1, cnt<=p_SETTLE, go to WAIT.
//  WAIT, while cnt>1: decrement cnt.
//  WAIT, at cnt==1: sample flags (exactly one of E/L/G must be high).
//   - E: RESULT<=PROBE, FOUND<=1, go to FIN.
//   - L: if PROBE==2^p_WIDTH-1 then ERR<=1, go to FIN; else lo<=PROBE+1, go to DRIVE.
//   - G: if PROBE==0 then ERR<=1, go to FIN; else hi<=PROBE-1, go to DRIVE.
//   - Zero or more than one flag high: ERR<=1, go to FIN.
//   - New lo>hi after an update: ERR<=1, go to FIN (unreachable with a consistent comparator).
//  Transition to FIN registers DONE<=1 and BUSY<=0 on the same edge.
//  FIN: DONE<=0 at the next edge, return to IDLE. DONE is high for exactly one cycle.
//  PROBE holds its last value in IDLE/FIN. RESULT/FOUND/ERR/ITER hold until the next accepted START.
//  START high while BUSY or in FIN is ignored (no restart, no queueing). START held high in IDLE
//   restarts immediately after FIN (back-to-back searches allowed).
//  Timing:
//   - Each probe costs 1+p_SETTLE cycles.
//   - First PROBE is valid 2 edges after the START edge.
//   - DONE rises (1+p_SETTLE)*ITER+1 edges after the START edge.
//   - Max ITER = p_WIDTH+1.
//  FOUND and ERR are never both 1.
// TESTING (bench: behavioural comparator, CMP_* = compare(PROBE, target); p_WIDTH=5, p_SETTLE=1)
//  T1 target=15, START pulse -> PROBE=15 first; DONE 3 edges after START; FOUND=1, RESULT=15, ITER=1, ERR=0.
//  T2 target=0 -> PROBE sequence 15,7,3,1,0; FOUND=1, RESULT=0, ITER=5; DONE 11 edges after START.
//  T3 target=31 -> PROBE sequence 15,23,27,29,30,31; FOUND=1, RESULT=31, ITER=6; DONE 13 edges after START.
//  T4 force CMP_E=CMP_L=CMP_G=0 -> after first probe: ERR=1, FOUND=0, ITER=1, single-cycle DONE.
//  T5 target=20, RESET_N=0 for one edge during second probe -> all outputs 0, IDLE, no DONE;
//     new START -> RESULT=20, FOUND=1.
//  T6 exhaustive: all 32 targets, p_SETTLE=1 and 3, START held high throughout ->
//     every result correct, ITER<=6, extra START pulses while BUSY ignored.

Source files
------------

// File: rtl/cmp_zelg_sar.sv
// cmp_zelg_sar: successive-approximation driver that binary-searches a comparator's hidden B operand
module cmp_zelg_sar #(
    parameter int p_WIDTH  = 5,
    parameter int p_SETTLE = 1
) (
    input  logic                           CLOCK_50,
    input  logic                           RESET_N,
    input  logic                           START,
    output logic [p_WIDTH-1:0]             PROBE,
    input  logic                           CMP_E,
    input  logic                           CMP_L,
    input  logic                           CMP_G,
    output logic                           BUSY,
    output logic                           DONE,
    output logic                           FOUND,
    output logic                           ERR,
    output logic [p_WIDTH-1:0]             RESULT,
    output logic [$clog2(p_WIDTH+2)-1:0]   ITER
);
    localparam int iw = $clog2(p_WIDTH + 2);
    localparam int cw = $clog2(p_SETTLE + 1);
    localparam logic [p_WIDTH:0] max_v = {1'b0, {p_WIDTH{1'b1}}};

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, FIN} state_t;

    state_t             state, state_n;
    logic [p_WIDTH:0]   lo, hi, probe_x, lo_up, hi_dn;
    logic [p_WIDTH-1:0] mid;
    logic [cw-1:0]      cnt;
    logic               sample, hit, go_lo, go_hi, fail;

    // Next-state and flag decode; a narrowing step is taken only if the new bounds stay ordered
    always_comb begin
        state_n = state;
        mid     = p_WIDTH'(lo + ((hi - lo) >> 1));
        probe_x = {1'b0, PROBE};
        lo_up   = probe_x + 1'b1;
        hi_dn   = probe_x - 1'b1;
        sample  = (state == WAIT) && (cnt == cw'(1));
        hit     = CMP_E && !CMP_L && !CMP_G;
        go_lo   = !CMP_E && CMP_L && !CMP_G && (probe_x != max_v) && (lo_up <= hi);
        go_hi   = !CMP_E && !CMP_L && CMP_G && (probe_x != '0) && (lo <= hi_dn);
        fail    = !hit && !go_lo && !go_hi;
        case (state)
            IDLE:    state_n = START ? DRIVE : IDLE;
            DRIVE:   state_n = WAIT;
            WAIT:    state_n = !sample ? WAIT : (go_lo || go_hi) ? DRIVE : FIN;
            default: state_n = IDLE;
        endcase
    end

    // State register and search datapath; DONE/BUSY are registered from the upcoming state
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state  <= IDLE;
            lo     <= '0;
            hi     <= '0;
            cnt    <= '0;
            PROBE  <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            FOUND  <= 1'b0;
            ERR    <= 1'b0;
            RESULT <= '0;
            ITER   <= '0;
        end else begin
            state <= state_n;
            DONE  <= (state_n == FIN);
            BUSY  <= (state_n == DRIVE) || (state_n == WAIT);
            case (state)
                IDLE: if (START) begin
                    lo    <= '0;
                    hi    <= max_v;
                    ITER  <= '0;
                    FOUND <= 1'b0;
                    ERR   <= 1'b0;
                end
                DRIVE: begin
                    PROBE <= mid;
                    ITER  <= ITER + iw'(1);
                    cnt   <= cw'(p_SETTLE);
                end
                WAIT: if (!sample) begin
                    cnt <= cnt - cw'(1);
                end else begin
                    ERR <= fail;
                    if (hit) begin
                        RESULT <= PROBE;
                        FOUND  <= 1'b1;
                    end
                    if (go_lo) lo <= lo_up;
                    if (go_hi) hi <= hi_dn;
                end
                default: ;
            endcase
        end
    end
endmodule
